// File: rtl/ram_sp_sr_rw_if.sv
// Bus interface for the single-port synchronous-read RAM.
// It groups the shared address, write data, enables and the registered read data.
interface ram_sp_sr_rw_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  we;
    logic                  cs;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output address,
        output data_in,
        output we,
        output cs,
        input  data_out
    );

    modport slave (
        input  address,
        input  data_in,
        input  we,
        input  cs,
        output data_out
    );
endinterface

// File: rtl/ram_sp_sr_rw.sv
// Single-port RAM with a registered read port, used as message/LLR storage in the LDPC decoder.
// The array has no reset so that it stays block-RAM inferable; only data_out is cleared.
module ram_sp_sr_rw #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    ram_sp_sr_rw_if.slave  bus
);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic                  in_range;
    logic                  do_write;
    logic                  do_read;

    // The range check exists only for partial depths; full depth needs no comparator.
    generate
        if (RAM_DEPTH < (1 << ADDR_WIDTH)) begin : g_partial_depth
            localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(RAM_DEPTH);
            assign in_range = (bus.address < DEPTH_LIMIT);
        end else begin : g_full_depth
            assign in_range = 1'b1;
        end
    endgenerate

    assign do_write = bus.cs &&  bus.we;
    assign do_read  = bus.cs && !bus.we;

    always_ff @(posedge clk) begin
        if (do_write && in_range) begin
            mem[bus.address] <= bus.data_in;
        end
    end

    // A write leaves data_out untouched; an out-of-range read returns zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_out <= '0;
        end else if (do_read) begin
            bus.data_out <= in_range ? mem[bus.address] : '0;
        end
    end

endmodule

// File: tb/tb_ram_sp_sr_rw.sv
// Self-checking bench: a full-depth and a reduced-depth (200 word) RAM driven with identical
// directed and random traffic, each compared against an array-based behavioural model.
module tb_ram_sp_sr_rw;

    localparam int DW          = 8;
    localparam int AW          = 8;
    localparam int SMALL_DEPTH = 200;

    logic clk;
    logic rst_n;

    ram_sp_sr_rw_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_full  ();
    ram_sp_sr_rw_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_small ();

    ram_sp_sr_rw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(1 << AW)) dut_full (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_full)
    );

    ram_sp_sr_rw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(SMALL_DEPTH)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_small)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] model_full  [256];
    logic [DW-1:0] model_small [256];
    bit            known_full  [256];
    bit            known_small [256];
    logic [DW-1:0] exp_full;
    logic [DW-1:0] exp_small;
    bit            exp_known_full;
    bit            exp_known_small;

    int vectors;
    int miscompares;

    // Words are only compared once their expected value is defined (array is unknown at power-up).
    task automatic checkOutput(input string tag);
        if (exp_known_full) begin
            vectors++;
            assert (bus_full.data_out === exp_full)
            else begin
                miscompares++;
                $error("[TB] FAIL %s (full): observed %h expected %h", tag, bus_full.data_out, exp_full);
            end
        end
        if (exp_known_small) begin
            vectors++;
            assert (bus_small.data_out === exp_small)
            else begin
                miscompares++;
                $error("[TB] FAIL %s (depth200): observed %h expected %h", tag, bus_small.data_out, exp_small);
            end
        end
    endtask

    task automatic updateModel(input bit c, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (c && w) begin
            model_full[a] = d;
            known_full[a] = 1'b1;
            if (int'(a) < SMALL_DEPTH) begin
                model_small[a] = d;
                known_small[a] = 1'b1;
            end
        end else if (c && !w) begin
            exp_full       = model_full[a];
            exp_known_full = known_full[a];
            if (int'(a) < SMALL_DEPTH) begin
                exp_small       = model_small[a];
                exp_known_small = known_small[a];
            end else begin
                exp_small       = '0;
                exp_known_small = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input bit c, input bit w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input string tag);
        bus_full.cs       = c;
        bus_full.we       = w;
        bus_full.address  = a;
        bus_full.data_in  = d;
        bus_small.cs      = c;
        bus_small.we      = w;
        bus_small.address = a;
        bus_small.data_in = d;
        @(posedge clk);
        #1;
        updateModel(c, w, a, d);
        checkOutput(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 256; i++) begin
            known_full[i]  = 1'b0;
            known_small[i] = 1'b0;
            model_full[i]  = '0;
            model_small[i] = '0;
        end

        // Reset held with a read presented: output must already be zero before any clock edge.
        rst_n             = 1'b0;
        bus_full.cs       = 1'b1;
        bus_full.we       = 1'b0;
        bus_full.address  = '0;
        bus_full.data_in  = '0;
        bus_small.cs      = 1'b1;
        bus_small.we      = 1'b0;
        bus_small.address = '0;
        bus_small.data_in = '0;
        exp_full          = '0;
        exp_small         = '0;
        exp_known_full    = 1'b1;
        exp_known_small   = 1'b1;
        #3;
        checkOutput("reset_async");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_held");
        rst_n = 1'b1;

        applyStimulus(1, 1, 8'h00, 8'h5A, "wr_addr0");
        applyStimulus(1, 0, 8'h00, 8'h00, "rd_addr0");

        for (int i = 0; i < 256; i++) applyStimulus(1, 1, 8'(i), 8'($urandom), "sweep_wr");
        for (int i = 0; i < 256; i++) applyStimulus(1, 0, 8'(i), 8'($urandom), "sweep_rd");

        applyStimulus(1, 1, 8'h03, 8'h11, "wr_addr3");
        applyStimulus(1, 0, 8'h03, 8'h00, "rd_addr3");
        applyStimulus(1, 1, 8'h07, 8'hEE, "wr_holds_out");
        applyStimulus(1, 0, 8'h07, 8'h00, "rd_addr7");

        applyStimulus(1, 1, 8'h04, 8'h44, "wr_addr4");
        applyStimulus(1, 1, 8'h09, 8'h22, "wr_addr9");
        applyStimulus(1, 0, 8'h09, 8'h00, "rd_addr9");
        applyStimulus(0, 1, 8'h04, 8'h99, "cs_idle_1");
        applyStimulus(0, 1, 8'h04, 8'h99, "cs_idle_2");
        applyStimulus(1, 0, 8'h04, 8'h00, "rd_after_idle");

        applyStimulus(1, 1, 8'hFF, 8'hA5, "wr_ff");
        applyStimulus(1, 0, 8'hFF, 8'h00, "rd_ff_a5");
        applyStimulus(1, 1, 8'hFF, 8'h3C, "wr_ff_again");
        applyStimulus(1, 0, 8'hFF, 8'h00, "rd_ff_3c");

        applyStimulus(1, 1, 8'd210, 8'h77, "wr_addr210");
        applyStimulus(1, 0, 8'd210, 8'h00, "rd_addr210");
        applyStimulus(1, 1, 8'd199, 8'hC3, "wr_addr199");
        applyStimulus(1, 0, 8'd199, 8'h00, "rd_addr199");
        applyStimulus(1, 0, 8'd200, 8'h00, "rd_addr200");

        // Reset between edges clears the output only; the write before it must survive.
        applyStimulus(1, 1, 8'h0C, 8'h5C, "wr_before_rst");
        applyStimulus(1, 0, 8'h09, 8'h00, "rd_before_rst");
        rst_n = 1'b0;
        #2;
        exp_full  = '0;
        exp_small = '0;
        checkOutput("reset_mid");
        rst_n = 1'b1;
        applyStimulus(1, 0, 8'h0C, 8'h00, "rd_after_rst");

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          8'($urandom), 8'($urandom), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
